// File: rtl/itof_pkg.sv
// itof_pkg: shared constants and stage record types for the integer-to-float converter.
package itof_pkg;
    localparam logic [7:0] BIAS    = 8'd127;
    localparam logic [7:0] EXP_TOP = BIAS + 8'd31;
    localparam int         STAGES  = 3;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } float_t;

    typedef struct packed {
        logic        valid;
        logic        s;
        logic        zero;
        logic [31:0] mag;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic        s;
        logic        zero;
        logic [7:0]  e;
        logic [31:0] norm;
    } s2_t;
endpackage

// File: rtl/itof_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter; all-zero input reports 31.
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  lz
);
    always_comb begin
        lz = 5'd31;
        for (int i = 0; i < 32; i++)
            if (a[i]) lz = 5'(31 - i);
    end
endmodule

// File: rtl/itof.sv
// itof: 3-stage int32 -> IEEE-754 single converter, round-to-nearest-even.
// Optional ITOF_INEXACT_EN adds a pipelined inexact flag alongside y.
module itof
    import itof_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        stage1_valid,
    output logic        ready,
    input  logic [31:0] x,
    input  logic        out_ready,
    output logic        valid,
`ifdef ITOF_INEXACT_EN
    output logic        inexact,
`endif
    output logic [31:0] y
);
    s1_t         s1;
    s2_t         s2;
    logic [4:0]  lz;
    logic        adv;
    logic        g;
    logic        st;
    logic [23:0] m;
    float_t      f;

    lzc32 u_lzc (.a(s1.mag), .lz(lz));

    assign adv   = !valid || out_ready;
    assign ready = adv;
    assign g     = s2.norm[7];
    assign st    = |s2.norm[6:0];
    // hidden bit rides along; a wrap of the 24-bit sum to 0 marks mantissa carry
    assign m      = s2.norm[31:8] + {23'd0, g && (st || s2.norm[8])};
    assign f.sign = s2.s;
    assign f.exp  = s2.e + {7'd0, !m[23]};
    assign f.frac = m[22:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1    <= '0;
            s2    <= '0;
            valid <= 1'b0;
            y     <= 32'h0;
`ifdef ITOF_INEXACT_EN
            inexact <= 1'b0;
`endif
        end else if (adv) begin
            s1    <= '{valid: stage1_valid, s: x[31], zero: x == 32'h0,
                       mag: x[31] ? ~x + 32'd1 : x};
            s2    <= '{valid: s1.valid, s: s1.s, zero: s1.zero,
                       e: EXP_TOP - {3'd0, lz}, norm: s1.mag << lz};
            valid <= s2.valid;
            y     <= s2.zero ? 32'h0 : f;
`ifdef ITOF_INEXACT_EN
            inexact <= !s2.zero && (g || st);
`endif
        end
    end
endmodule

// File: tb/tb_itof.sv
// tb_itof: scoreboard bench for itof with an arithmetic reference model.
// Define ITOF_INEXACT_EN for both RTL and bench to cover the inexact flag.
module tb_itof;
    import itof_pkg::*;

    logic        clk = 0;
    logic        rstn = 0;
    logic        stage1_valid = 0;
    logic        ready;
    logic [31:0] x = 0;
    logic        out_ready = 1;
    logic        valid;
    logic [31:0] y;
    logic        inexact_w;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int bp_mode = 0;
    bit lat_chk = 0;
    logic [32:0] exp_q[$];
    int          t_q[$];

    itof dut (
        .clk(clk), .rstn(rstn), .stage1_valid(stage1_valid), .ready(ready),
        .x(x), .out_ready(out_ready), .valid(valid),
`ifdef ITOF_INEXACT_EN
        .inexact(inexact_w),
`endif
        .y(y)
    );
`ifndef ITOF_INEXACT_EN
    assign inexact_w = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // {inexact, y} from magnitude, top-bit position and remainder-vs-half rounding
    function automatic logic [32:0] model(input logic [31:0] v);
        longint m, q, rem, half;
        int p, sh;
        logic s;
        logic [31:0] r;
        s = v[31];
        m = s ? -longint'($signed(v)) : longint'(v);
        if (m == 0) return 33'h0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        rem = 0;
        if (p <= 23) q = m << (23 - p);
        else begin
            sh = p - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q % 2 == 1)) q++;
            if (q == (longint'(1) << 24)) begin q = q >> 1; p++; end
        end
        r = {s, 8'(127 + p), 23'(q & 64'h7FFFFF)};
        return {rem != 0, r};
    endfunction

    task automatic send(input logic [31:0] v, input logic [32:0] e);
        int n = 0;
        @(posedge clk); #1;
        stage1_valid = 1; x = v;
        @(negedge clk);
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (!ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: ready stuck at %b expected 1", ready);
        end else begin
            exp_q.push_back(e);
            t_q.push_back(cyc);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        stage1_valid = 0;
    endtask

    logic        pv = 0, po = 0;
    logic [31:0] py = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        int t;
        if (!rstn) pv = 0;
        else begin
            chk("ready", {31'd0, ready}, {31'd0, !valid || out_ready});
            if (pv && !po) begin
                chk("stall_valid", {31'd0, valid}, 32'd1);
                chk("stall_y", y, py);
            end
            if (valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", y);
                end else begin
                    e = exp_q.pop_front();
                    t = t_q.pop_front();
                    chk("y", y, e[31:0]);
`ifdef ITOF_INEXACT_EN
                    chk("inexact", {31'd0, inexact_w}, {31'd0, e[32]});
`endif
                    if (lat_chk) chk("latency", cyc - t, STAGES);
                end
            end
            pv = valid; po = out_ready; py = y;
        end
    end

    logic [31:0] dx[10] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h80000000,
                            32'd16777217, 32'd16777219, 32'd16777221, 32'd1024, 32'h80000001};
    logic [31:0] dy[10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h4F000000, 32'hCF000000,
                            32'h4B800000, 32'h4B800002, 32'h4B800002, 32'h44800000, 32'hCF000000};

    initial begin
        logic [32:0] m;
        logic [31:0] r, v;
        int k, sel, n;
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1;
`ifdef ITOF_INEXACT_EN
        m = model(32'd16777217); chk("model_inexact_tie", {31'd0, m[32]}, 32'd1);
`endif
        lat_chk = 1;
        for (int i = 0; i < 10; i++) begin
            m = model(dx[i]);
            send(dx[i], {m[32], dy[i]});
        end
        idle();
        repeat (6) @(negedge clk);
        lat_chk = 0;

        fork
            for (int i = 0; i < 5; i++) begin
                v = 32'(i * 1000003 + 7);
                send(v, model(v));
            end
            begin
                repeat (4) @(negedge clk);
                bp_mode = 2;
                repeat (4) @(negedge clk);
                bp_mode = 0;
            end
        join
        idle();
        repeat (8) @(negedge clk);
        chk("stall_drain", exp_q.size(), 0);

        send(32'd5, model(32'd5));
        send(32'd6, model(32'd6));
        send(32'd7, model(32'd7));
        @(posedge clk); #1;
        stage1_valid = 0;
        #1 rstn = 0;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_y", y, 32'h0);
        exp_q.delete();
        t_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1;
        lat_chk = 1;
        send(32'd9, model(32'd9));
        idle();
        repeat (5) @(negedge clk);
        lat_chk = 0;

        bp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            k = $urandom_range(0, 31);
            sel = $urandom_range(0, 3);
            v = (sel == 0) ? r : (sel == 1) ? (r >> k) :
                (sel == 2) ? (32'd1 << k) + 32'($urandom_range(0, 2)) - 32'd1 : -(r >> k);
            send(v, model(v));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        @(negedge clk);
        bp_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("final_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
